// File: rtl/adder_sum_accumulator.sv
// Sums g_num_terms valid adder outputs into one frame total and presents it on a
// single-entry valid/ready holding register. The input is never stalled; a dropped total is flagged.
module adder_sum_accumulator #(
    parameter int unsigned g_data_width = 8,
    parameter int unsigned g_num_terms  = 4,
    localparam int unsigned g_sum_width = g_data_width + 1 + $clog2(g_num_terms),
    localparam int unsigned g_cnt_width = $clog2(g_num_terms + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [g_data_width:0]   i_C,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [g_sum_width-1:0]  o_sum,
    output logic [g_cnt_width-1:0]  o_count,
    output logic                    o_overrun
);

    typedef logic [g_sum_width-1:0] sum_t;
    typedef logic [g_cnt_width-1:0] cnt_t;
    typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

    out_state_e state_q, state_d;
    sum_t       acc_q, acc_d;
    sum_t       sum_q, sum_d;
    cnt_t       count_q, count_d;
    logic       overrun_q, overrun_d;

    logic       last_term;
    logic       complete;
    logic       handshake;
    sum_t       total;

    assign last_term = (count_q == cnt_t'(g_num_terms - 1));
    assign complete  = i_valid && last_term;
    assign handshake = (state_q == StFull) && i_ready;
    assign total     = acc_q + sum_t'(i_C);

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if (i_valid) begin
            if (last_term) begin
                acc_d   = '0;
                count_d = '0;
            end else begin
                acc_d   = total;
                count_d = count_q + cnt_t'(1);
            end
        end
    end

    // A handshake frees the register on the same edge, so a coincident total loads without a bubble.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    sum_d   = total;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (handshake) begin
                    if (complete) begin
                        sum_d = total;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (complete) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StEmpty;
            acc_q     <= '0;
            sum_q     <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_valid   = (state_q == StFull);
    assign o_sum     = sum_q;
    assign o_count   = count_q;
    assign o_overrun = overrun_q;

endmodule
